// File: rtl/gf_ops_pkg.sv
// Shared types and constants for the sequential adder subsystem.
package gf_ops_pkg;

  localparam int ADD_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } add_arb_state_t;

  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/gf_add_arbiter_rr.sv
// Combinational round-robin grant search starting just above the last winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int W = $clog2(N);

  logic found;
  int   p;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    p       = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(last) + 1 + k;
      if (p >= N) p = p - N;
      if (!found && req[p]) begin
        found   = 1'b1;
        gnt[p]  = 1'b1;
        gnt_idx = W'(p);
      end
    end
  end

endmodule

// File: rtl/gf_add_arbiter.sv
// Round-robin front end sharing one fixed-latency adder among requesters,
// one operation at a time, with a single tagged response channel.
module gf_add_arbiter
  import gf_ops_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = ADD_LATENCY_DEF,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  input  logic [DATA_WIDTH-1:0]         add_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy
);

  localparam int CNT_W = cnt_width(ADD_LATENCY);

  add_arb_state_t     state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    op_id;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0]   cnt;
  logic               idle_ok;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Reset masks the status outputs in the same cycle it is raised.
  assign idle_ok   = (state == IDLE) && !resetn;
  assign req_ready = idle_ok ? gnt : '0;
  assign busy      = (state != IDLE) && !resetn;
  assign rsp_valid = (state == RESP) && !resetn;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      op_id      <= '0;
      cnt        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            add_a      <= req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            add_b      <= req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            op_id      <= gnt_idx;
            last_grant <= gnt_idx;
            cnt        <= CNT_W'(ADD_LATENCY);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_data <= add_result;
            rsp_id   <= op_id;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_add_arbiter.sv
// Randomized and directed bench for gf_add_arbiter with a timestamp-based model.
module tb_gf_add_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int L  = 2;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic [DW-1:0]  add_a, add_b, add_result;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [DW-1:0]  rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;

  logic [DW-1:0]  r1 = '0, r2 = '0;

  int n_chk = 0;
  int n_pass = 0;

  gf_add_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .ADD_LATENCY(L), .ID_W(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural adder: L register stages from operands to result.
  always @(posedge clk) begin
    r1 <= add_a + add_b;
    r2 <= r1;
  end
  assign add_result = r2;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Model: an operation is described by its accept cycle and operands.
  bit          m_init = 0;
  bit          m_active = 0;
  int          m_acc = 0;
  int          cyc = 0;
  int          m_last = NR - 1;
  int          m_id = 0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_rd = '0;
  logic [1:0]  m_rid = '0;
  logic [NR-1:0] e_rdy;
  bit          e_val, e_busy;
  int          g, j;

  always @(negedge clk) begin
    e_rdy  = '0;
    e_val  = 1'b0;
    e_busy = 1'b0;
    g      = -1;
    if (!resetn && !m_active) begin
      for (int k = 1; k <= NR; k++) begin
        j = (m_last + k) % NR;
        if (g < 0 && req_valid[j]) g = j;
      end
      if (g >= 0) e_rdy[g] = 1'b1;
    end else if (!resetn) begin
      e_busy = 1'b1;
      e_val  = (cyc - m_acc) >= 2 + L;
    end
    if (m_init) begin
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_val));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("add_a", 64'(add_a), 64'(m_a));
      chk("add_b", 64'(add_b), 64'(m_b));
      chk("rsp_data", 64'(rsp_data), 64'(m_rd));
      chk("rsp_id", 64'(rsp_id), 64'(m_rid));
    end
    if (resetn) begin
      m_init   = 1;
      m_active = 0;
      m_last   = NR - 1;
      m_a      = '0;
      m_b      = '0;
      m_rd     = '0;
      m_rid    = '0;
    end else if (!m_active) begin
      if (g >= 0) begin
        m_active = 1;
        m_acc    = cyc;
        m_a      = req_a[g*DW +: DW];
        m_b      = req_b[g*DW +: DW];
        m_id     = g;
        m_last   = g;
      end
    end else begin
      if (cyc - m_acc == 1 + L) begin
        m_rd  = m_a + m_b;
        m_rid = 2'(m_id);
      end
      if (e_val && rsp_ready) m_active = 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic do_reset();
    resetn    = 1'b1;
    req_valid = '1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    resetn    = 1'b0;
    req_valid = '0;
  endtask

  task automatic get_rsp(output logic [DW-1:0] d, output logic [1:0] id);
    bit ok;
    ok = 0;
    d  = '0;
    id = '0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid && rsp_ready) begin
        d  = rsp_data;
        id = rsp_id;
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  logic [DW-1:0] d, hd;
  logic [1:0]    id, hid;
  int            n;

  initial begin
    tick();
    do_reset();

    // single request, latency from accept
    set_op(1, 32'h5, 32'h3);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("single_lat", 64'(n), 64'd4);
    chk("single_data", 64'(rsp_data), 64'h8);
    chk("single_id", 64'(rsp_id), 64'd1);
    tick();

    // round robin from fresh reset
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, DW'(i), 32'h10);
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      get_rsp(d, id);
      chk("rr_id", 64'(id), 64'(i % NR));
      chk("rr_data", 64'(d), 64'(32'h10 + (i % NR)));
    end
    req_valid = '0;
    while (busy) tick();

    // adder wrap passes through
    set_op(2, 32'hFFFF_FFFF, 32'h2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    get_rsp(d, id);
    chk("wrap_data", 64'(d), 64'h1);
    chk("wrap_id", 64'(id), 64'd2);

    // backpressure
    rsp_ready = 1'b0;
    set_op(0, 32'h1234, 32'h1111);
    req_valid = 4'b0001;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    hd  = rsp_data;
    hid = rsp_id;
    chk("bp_data", 64'(hd), 64'h2345);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_stable", 64'({rsp_id, rsp_data}), 64'({hid, hd}));
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle", 64'(busy), 64'd0);
    chk("bp_accept", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    chk("bp_busy", 64'(busy), 64'd1);
    get_rsp(d, id);

    // reset mid-BUSY
    set_op(1, 32'h77, 32'h1);
    set_op(0, 32'h40, 32'h2);
    set_op(2, 32'h50, 32'h3);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_valid", 64'(rsp_valid), 64'd0);
    chk("mr_data", 64'(rsp_data), 64'd0);
    chk("mr_add_a", 64'(add_a), 64'd0);
    chk("mr_ready", 64'(req_ready), 64'b0001);
    tick();
    get_rsp(d, id);
    chk("mr_first_id", 64'(id), 64'd0);
    chk("mr_first_data", 64'(d), 64'h42);

    // fairness skip
    set_op(3, 32'h9, 32'h9);
    req_valid = 4'b1001;
    get_rsp(d, id);
    chk("fair_id0", 64'(id), 64'd3);
    get_rsp(d, id);
    chk("fair_id1", 64'(id), 64'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      req_valid = NR'($urandom);
      for (int k = 0; k < NR; k++) set_op(k, $urandom, $urandom);
      rsp_ready = ($urandom % 4) != 0;
      resetn    = ($urandom % 60) == 0;
      tick();
    end
    resetn = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
